// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin arbiter for the register file write port
// Optional: REGFILE_R0_PROTECT_EN suppresses the write enable for address 0.
module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 16,
  parameter int AW   = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 hold_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  input  logic [NREQ*DW-1:0]   req_data_i,
  output logic [NREQ-1:0]      ack_o,
  output logic [(1<<AW)-1:0]   wr_en_n_o,
  output logic [AW-1:0]        wr_addr_o,
  output logic [DW-1:0]        wr_data_o,
  output logic                 busy_o
);

  localparam int NWE = 1 << AW;
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_IDLE, S_WRITE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NWE-1:0]  wr_en_n_q, wr_en_n_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            busy_q, busy_d;

  logic            grant_valid;
  logic [PW-1:0]   grant_idx;
  logic [AW-1:0]   grant_addr;
  logic [DW-1:0]   grant_data;

  function automatic logic [NWE-1:0] decode_we(input logic [AW-1:0] a);
    logic [NWE-1:0] onehot;
    onehot    = '0;
    onehot[a] = 1'b1;
`ifdef REGFILE_R0_PROTECT_EN
    if (a == '0) onehot = '0;
`else
`endif
    return ~onehot;
  endfunction

  // Search starts at rr_ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    int cand;
    cand        = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = int'(rr_ptr_q) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grant_valid && req_i[PW'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = PW'(cand);
      end
    end
  end

  assign grant_addr = req_addr_i[int'(grant_idx)*AW +: AW];
  assign grant_data = req_data_i[int'(grant_idx)*DW +: DW];

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    ack_d     = '0;
    wr_en_n_d = '1;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!hold_i && grant_valid) begin
          wr_addr_d        = grant_addr;
          wr_data_d        = grant_data;
          wr_en_n_d        = decode_we(grant_addr);
          ack_d[grant_idx] = 1'b1;
          busy_d           = 1'b1;
          rr_ptr_d         = (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + 1'b1;
          state_d          = S_WRITE;
        end
      end
      // The write always completes; hold only blocks the next grant.
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      ack_q     <= '0;
      wr_en_n_q <= '1;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      ack_q     <= ack_d;
      wr_en_n_q <= wr_en_n_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign ack_o     = ack_q;
  assign wr_en_n_o = wr_en_n_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed and random checks of regfile_wr_arbiter against a write-level model
module tb_regfile_wr_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int NWE  = 1 << AW;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                hold;
  logic [NREQ-1:0]     req;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     ack;
  logic [NWE-1:0]      wr_en_n;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;
  logic                busy;

  int checks = 0;
  int failures = 0;

  // Reference model: what the write port should show after each edge.
  bit              m_busy;
  int              m_ptr;
  logic [NREQ-1:0] m_ack;
  logic [NWE-1:0]  m_en;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;

  int ack_order[$];

  regfile_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .hold_i(hold), .req_i(req),
    .req_addr_i(req_addr), .req_data_i(req_data), .ack_o(ack),
    .wr_en_n_o(wr_en_n), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NWE-1:0] exp_enable(input logic [AW-1:0] a);
    logic [NWE-1:0] e;
    e = 8'hFF & ~(8'd1 << a);
`ifdef REGFILE_R0_PROTECT_EN
    if (a == 0) e = 8'hFF;
`else
`endif
    return e;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_ack = '0; m_en = '1; m_addr = '0; m_data = '0;
  endtask

  task automatic model_edge();
    int w;
    if (!rst_n) begin
      model_reset();
    end else if (m_busy) begin
      m_busy = 0; m_ack = '0; m_en = '1;
    end else if (!hold && (req != 0)) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      m_addr = req_addr[w*AW +: AW];
      m_data = req_data[w*DW +: DW];
      m_en   = exp_enable(m_addr);
      m_ack  = NREQ'(1) << w;
      m_busy = 1;
      m_ptr  = (w + 1) % NREQ;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".ack"},     32'(ack),     32'(m_ack));
    check({tag, ".wr_en_n"}, 32'(wr_en_n), 32'(m_en));
    check({tag, ".wr_addr"}, 32'(wr_addr), 32'(m_addr));
    check({tag, ".wr_data"}, 32'(wr_data), 32'(m_data));
    check({tag, ".busy"},    32'(busy),    32'(m_busy));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
    if (ack != 0)
      for (int i = 0; i < NREQ; i++) if (ack[i]) ack_order.push_back(i);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    hold = 1'b0; req = '0; req_addr = '0; req_data = '0;
    model_reset();
    do_reset();
    compare_all("reset");

    // Single write from requester 1
    set_req(1, 3'd5, 16'hBEEF);
    tick("single_grant");
    check("single.wr_en_n", 32'(wr_en_n), 32'h0000_00DF);
    check("single.ack", 32'(ack), 32'h2);
    check("single.wr_data", 32'(wr_data), 32'hBEEF);
    req = '0;
    tick("single_end");
    check("single.release", 32'(wr_en_n), 32'h0000_00FF);
    tick("single_idle");

    // Round-robin with all requesters persistent
    do_reset();
    ack_order.delete();
    set_req(0, 3'd1, 16'h1111); set_req(1, 3'd2, 16'h2222); set_req(2, 3'd3, 16'h3333);
    for (int c = 0; c < 12; c++) begin
      tick("rr");
      check("rr.busy_phase", 32'(busy), 32'((c % 2) == 0));
    end
    check("rr.count", 32'(ack_order.size()), 32'd6);
    for (int i = 0; i < 6 && i < ack_order.size(); i++)
      check($sformatf("rr.order%0d", i), 32'(ack_order[i]), 32'(i % 3));
    req = '0;
    tick("rr_drain");

    // Hold blocks grants until released
    do_reset();
    hold = 1'b1;
    set_req(0, 3'd4, 16'hA5A5);
    for (int c = 0; c < 4; c++) begin
      tick("hold");
      check("hold.ack", 32'(ack), 32'h0);
      check("hold.en", 32'(wr_en_n), 32'hFF);
    end
    hold = 1'b0;
    tick("hold_release");
    check("hold_release.ack", 32'(ack), 32'h1);

    // Hold rising during WRITE does not cancel that write
    hold = 1'b1;
    tick("hold_in_write");
    check("hold_in_write.ack", 32'(ack), 32'h0);
    req = '0;
    hold = 1'b0;
    set_req(0, 3'd6, 16'h0606);
    tick("hwr_grant");
    check("hwr.en", 32'(wr_en_n), 32'hBF);
    check("hwr.ack", 32'(ack), 32'h1);
    hold = 1'b1;
    tick("hwr_complete");
    check("hwr.done_en", 32'(wr_en_n), 32'hFF);
    tick("hwr_nogrant");
    check("hwr.nogrant", 32'(ack), 32'h0);
    hold = 1'b0; req = '0;
    tick("hwr_idle");

    // Write to R0
    set_req(2, 3'd0, 16'h1234);
    tick("r0");
    check("r0.ack", 32'(ack), 32'h4);
`ifdef REGFILE_R0_PROTECT_EN
    check("r0.en", 32'(wr_en_n), 32'hFF);
`else
    check("r0.en", 32'(wr_en_n), 32'hFE);
`endif
    req = '0;
    tick("r0_end");

    // Reset during WRITE aborts; held req0 granted right after release
    set_req(0, 3'd7, 16'h7777);
    tick("rst_grant");
    check("rst.in_write", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.async_en", 32'(wr_en_n), 32'hFF);
    check("rst.async_ack", 32'(ack), 32'h0);
    check("rst.async_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("rst_regrant");
    check("rst.regrant_ack", 32'(ack), 32'h1);
    req = '0;
    tick("rst_end");

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      hold = ($urandom_range(0, 5) == 0);
      req  = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_addr[i*AW +: AW] = AW'($urandom);
        req_data[i*DW +: DW] = DW'($urandom);
      end
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
